// File: rtl/reg_dump_reader.sv
// Debug reader that walks register indices FIRST_REG..LAST_REG over a spare read port and streams them out.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum word (dump_idx = 2**ADDR_W) after the last register.
module reg_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W:0]   dump_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
`ifdef REG_DUMP_CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W:0]     didx_q, didx_d;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CSUM_IDX = {1'b1, {ADDR_W{1'b0}}};
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    didx_d  = didx_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = rs_data;
        didx_d  = {1'b0, idx_q};
        valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q ^ rs_data;
`endif
        state_d = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum word is presented in the very cycle CSUM is entered.
            data_d  = csum_q;
            didx_d  = CSUM_IDX;
            valid_d = 1'b1;
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      didx_q  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      didx_q  <= didx_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign rs_addr    = (state_q == IDLE) ? '0 : idx_q;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_idx   = didx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed self-checking bench for reg_dump_reader: reset, full dump timing, stall, restart attempt,
// mid-dump reset and the checksum word (only present when REG_DUMP_CHECKSUM_EN is defined).
module tb_reg_dump_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int EXP_WORDS  = 33;
  localparam int DONE_CYCLE = 66;
`else
  localparam int EXP_WORDS  = 32;
  localparam int DONE_CYCLE = 65;
`endif

  logic              CLK;
  logic              RST;
  logic              start;
  logic [ADDR_W-1:0] rs_addr;
  logic [DATA_W-1:0] rs_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W:0]   dump_idx;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] regs [32];
  int checks;
  int errors;

  reg_dump_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIRST_REG(0), .LAST_REG(31)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .rs_addr(rs_addr), .rs_data(rs_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_idx(dump_idx),
    .busy(busy), .done(done)
  );

  // Combinational register-file read port model
  assign rs_data = regs[rs_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse; returns at the sample point of the cycle after start
  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] modelCsum();
    logic [DATA_W-1:0] c = '0;
    for (int i = 0; i < 32; i++) c = c ^ regs[i];
    return c;
  endfunction

  // Runs one dump, optionally stalling on one word and re-pulsing start at another.
  task automatic collectDump(input int stallIdx, input int stallLen, input int restartIdx);
    int expIdx = 0;
    int words = 0;
    int doneCnt = 0;
    int stallLeft = stallLen;
    int finished = 0;
    int restarted = 0;
    logic [63:0] wantIdx;
    logic [63:0] wantData;
    dump_ready = 1'b1;
    applyStimulus();
    for (int cyc = 0; cyc < 400 && finished == 0; cyc++) begin
      start = 1'b0;
      if (done) begin
        doneCnt++;
        tick();
        tick();
        checkOutput("busy_after_done", {63'd0, busy}, 64'd0);
        checkOutput("done_single_pulse", {63'd0, done}, 64'd0);
        checkOutput("valid_after_done", {63'd0, dump_valid}, 64'd0);
        finished = 1;
      end else begin
        if (dump_valid) begin
          if (stallLeft > 0 && int'(dump_idx) == stallIdx) begin
            checkOutput("stall_idx", {58'd0, dump_idx}, 64'(stallIdx));
            checkOutput("stall_data", {32'd0, dump_data}, {32'd0, regs[stallIdx]});
            dump_ready = 1'b0;
            stallLeft--;
          end else begin
            wantIdx  = (expIdx <= 31) ? 64'(expIdx) : 64'd32;
            wantData = (expIdx <= 31) ? {32'd0, regs[expIdx]} : {32'd0, modelCsum()};
            checkOutput("word_idx", {58'd0, dump_idx}, wantIdx);
            checkOutput("word_data", {32'd0, dump_data}, wantData);
            dump_ready = 1'b1;
            expIdx++;
            words++;
          end
          if (restartIdx >= 0 && restarted == 0 && int'(dump_idx) == restartIdx) begin
            start = 1'b1;
            restarted = 1;
          end
        end
        tick();
      end
    end
    start = 1'b0;
    checkOutput("dump_finished", 64'(finished), 64'd1);
    checkOutput("word_count", 64'(words), 64'(EXP_WORDS));
    checkOutput("done_count", 64'(doneCnt), 64'd1);
  endtask

  initial begin
    int found;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) regs[i] = DATA_W'(i);

    // Reset held for two cycles with start asserted
    RST = 1'b1;
    start = 1'b1;
    dump_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      tick();
      checkOutput("rst_rs_addr", {59'd0, rs_addr}, 64'd0);
      checkOutput("rst_valid", {63'd0, dump_valid}, 64'd0);
      checkOutput("rst_data", {32'd0, dump_data}, 64'd0);
      checkOutput("rst_idx", {58'd0, dump_idx}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_done", {63'd0, done}, 64'd0);
    end
    RST = 1'b0;
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      checkOutput("post_rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("post_rst_valid", {63'd0, dump_valid}, 64'd0);
    end

    // Full dump at full throughput with exact cycle timing
    $display("[TB] full dump timing");
    dump_ready = 1'b1;
    applyStimulus();
    for (int c = 1; c <= 68; c++) begin
      logic expValid;
      expValid = (c >= 2 && c <= 64 && (c % 2) == 0);
`ifdef REG_DUMP_CHECKSUM_EN
      if (c == 65) expValid = 1'b1;
`endif
      checkOutput("t_valid", {63'd0, dump_valid}, {63'd0, expValid});
      checkOutput("t_done", {63'd0, done}, {63'd0, (c == DONE_CYCLE)});
      checkOutput("t_busy", {63'd0, busy}, {63'd0, (c <= DONE_CYCLE)});
      if (c <= 64) checkOutput("t_rs_addr", {59'd0, rs_addr}, 64'((c - 1) / 2));
      if (expValid && c <= 64) begin
        checkOutput("t_idx", {58'd0, dump_idx}, 64'((c - 2) / 2));
        checkOutput("t_data", {32'd0, dump_data}, 64'((c - 2) / 2));
      end
      if (expValid && c == 65) begin
        checkOutput("t_csum_idx", {58'd0, dump_idx}, 64'd32);
        checkOutput("t_csum_data", {32'd0, dump_data}, 64'd0);
      end
      tick();
    end
    checkOutput("idle_rs_addr", {59'd0, rs_addr}, 64'd0);

    // Stall on idx 7 for 5 cycles, then a start pulse while idx 10 is valid
    $display("[TB] stall and start-while-busy");
    collectDump(7, 5, 10);

    // Reset in the middle of the dump at idx 15
    $display("[TB] mid-dump reset");
    dump_ready = 1'b1;
    applyStimulus();
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (dump_valid && dump_idx == 6'd15) found = 1;
      else tick();
    end
    checkOutput("reached_idx15", 64'(found), 64'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("abort_valid", {63'd0, dump_valid}, 64'd0);
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("abort_no_done", {63'd0, done}, 64'd0);
      checkOutput("abort_no_valid", {63'd0, dump_valid}, 64'd0);
    end
    collectDump(-1, 0, -1);

    // Checksum pattern: x0=0, x1..x31=1 gives checksum 1 when enabled
    $display("[TB] checksum pattern");
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = 32'h0000_0001;
    collectDump(-1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
